// File: rtl/anspwm_pkg.sv
// Shared defaults and sign-magnitude helpers for the PWM combiner.
package anspwm_pkg;

  localparam int unsigned CNT_W_DEF = 8;
  localparam int unsigned IN_W_DEF  = 16;

  typedef logic signed [IN_W_DEF+2:0] sum_t;

  function automatic sum_t sm_to_signed(input logic [IN_W_DEF-1:0] mag, input logic sgn);
    sum_t m;
    m = sum_t'(mag);
    return sgn ? -m : m;
  endfunction

endpackage

// File: rtl/pwm_combine_out_pwm_counter.sv
// Free-running frame counter, frame strobe and PWM comparator.
module pwm_counter
  import anspwm_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W:0]   duty_next,
  output logic             wrap,
  output logic             frame,
  output logic             pwm_out
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             frame_q, frame_d;
  logic             pwm_q, pwm_d;

  // Compare against next-cycle count and duty so the pulse starts with the frame strobe
  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    wrap    = (cnt_q == '1);
    frame_d = (cnt_d == '0);
    pwm_d   = ({1'b0, cnt_d} < duty_next);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      frame_q <= 1'b0;
      pwm_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      pwm_q   <= pwm_d;
    end
  end

  assign frame   = frame_q;
  assign pwm_out = pwm_q;

endmodule

// File: rtl/pwm_combine_out.sv
// Sign-magnitude combiner, saturating clamp and double-buffered PWM duty.
// Optional status counters enabled by PWM_COMBINE_STATUS_EN.
module pwm_combine_out
  import anspwm_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned IN_W  = IN_W_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [IN_W-1:0] A,
  input  logic [IN_W-1:0] B,
  input  logic            Bsgn,
  input  logic [IN_W-1:0] C,
  input  logic            Csgn,
  output logic            pwm_out,
  output logic            frame,
  output logic            underrun,
  output logic            sat
`ifdef PWM_COMBINE_STATUS_EN
  ,
  input  logic            stat_clr,
  output logic [15:0]     sat_cnt,
  output logic [15:0]     underrun_cnt
`endif
);

  localparam int unsigned SW = IN_W + 3;
  typedef logic signed [SW-1:0] s_t;
  localparam s_t             FULL   = s_t'(2**CNT_W);
  localparam logic [CNT_W:0] FULL_D = {1'b1, {CNT_W{1'b0}}};

  s_t             sum_q, sum_d;
  logic           v1_q, v1_d;
  logic [CNT_W:0] pending_q, pending_d;
  logic           pend_new_q, pend_new_d;
  logic [CNT_W:0] duty_q, duty_d;
  logic           underrun_q, underrun_d;
  logic           sat_q, sat_d;
  logic [CNT_W:0] clamp_val;
  logic           clamped;
  logic           wrap;

  // A pending write landing on the wrap cycle feeds duty directly and is not left marked new
  always_comb begin
    sum_d = s_t'(A) + (Bsgn ? -s_t'(B) : s_t'(B)) + (Csgn ? -s_t'(C) : s_t'(C));
    v1_d  = in_valid;

    clamped   = 1'b0;
    clamp_val = sum_q[CNT_W:0];
    if (sum_q < 0) begin
      clamp_val = '0;
      clamped   = 1'b1;
    end else if (sum_q > FULL) begin
      clamp_val = FULL_D;
      clamped   = 1'b1;
    end

    pending_d  = v1_q ? clamp_val : pending_q;
    sat_d      = v1_q & clamped;
    duty_d     = duty_q;
    underrun_d = 1'b0;
    pend_new_d = pend_new_q | v1_q;
    if (wrap) begin
      duty_d     = pending_d;
      underrun_d = !(pend_new_q | v1_q);
      pend_new_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q      <= '0;
      v1_q       <= 1'b0;
      pending_q  <= '0;
      pend_new_q <= 1'b0;
      duty_q     <= '0;
      underrun_q <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      sum_q      <= sum_d;
      v1_q       <= v1_d;
      pending_q  <= pending_d;
      pend_new_q <= pend_new_d;
      duty_q     <= duty_d;
      underrun_q <= underrun_d;
      sat_q      <= sat_d;
    end
  end

  pwm_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .duty_next (duty_d),
    .wrap      (wrap),
    .frame     (frame),
    .pwm_out   (pwm_out)
  );

  assign underrun = underrun_q;
  assign sat      = sat_q;

`ifdef PWM_COMBINE_STATUS_EN
  logic [15:0] sat_cnt_q, sat_cnt_d;
  logic [15:0] und_cnt_q, und_cnt_d;

  always_comb begin
    sat_cnt_d = sat_cnt_q;
    und_cnt_d = und_cnt_q;
    if (stat_clr) begin
      sat_cnt_d = '0;
      und_cnt_d = '0;
    end else begin
      if (sat_d && (sat_cnt_q != '1))      sat_cnt_d = sat_cnt_q + 16'd1;
      if (underrun_d && (und_cnt_q != '1)) und_cnt_d = und_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt_q <= '0;
      und_cnt_q <= '0;
    end else begin
      sat_cnt_q <= sat_cnt_d;
      und_cnt_q <= und_cnt_d;
    end
  end

  assign sat_cnt      = sat_cnt_q;
  assign underrun_cnt = und_cnt_q;
`endif

endmodule

// File: tb/tb_pwm_combine_out.sv
// Directed bench for pwm_combine_out; frame-by-frame duty, sat and underrun checks.
module tb_pwm_combine_out;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] A, B, C;
  logic        Bsgn, Csgn;
  logic        pwm_out, frame, underrun, sat;
`ifdef PWM_COMBINE_STATUS_EN
  logic        stat_clr;
  logic [15:0] sat_cnt, underrun_cnt;
`endif

  always #5 clk = ~clk;

  pwm_combine_out #(.CNT_W(8), .IN_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .A            (A),
    .B            (B),
    .Bsgn         (Bsgn),
    .C            (C),
    .Csgn         (Csgn),
    .pwm_out      (pwm_out),
    .frame        (frame),
    .underrun     (underrun),
    .sat          (sat)
`ifdef PWM_COMBINE_STATUS_EN
    ,
    .stat_clr     (stat_clr),
    .sat_cnt      (sat_cnt),
    .underrun_cnt (underrun_cnt)
`endif
  );

  typedef struct {
    int j;
    int a, b, c;
    bit bs, cs;
  } samp_t;

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input samp_t s);
    in_valid = 1'b1;
    A    = 16'(s.a);
    B    = 16'(s.b);
    C    = 16'(s.c);
    Bsgn = s.bs;
    Csgn = s.cs;
  endtask

  // Called at the negedge of a frame cycle; leaves off at the next frame cycle
  task automatic run_frame(input samp_t s1, input samp_t s2,
                           output int hi, output int und, output int sats, output int badf);
    hi = 0; und = 0; sats = 0; badf = 0;
    for (int k = 0; k < 256; k++) begin
      if (pwm_out) hi++;
      if (sat) sats++;
      if (k == 0) und = int'(underrun);
      else if (underrun) badf++;
      if (frame != (k == 0)) badf++;
      in_valid = 1'b0;
      if (k == s1.j) drive(s1);
      else if (k == s2.j) drive(s2);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_frame(output int n, output int hi);
    n = 0; hi = 0;
    while (!frame && n < 600) begin
      if (pwm_out) hi++;
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    samp_t none, s2, s3, s4, s40, s80, s200;
    int hi, und, sats, badf, n;

    none = '{j: -1, a: 0, b: 0, c: 0, bs: 0, cs: 0};
    s2   = '{j: 50,  a: 100, b: 10, c: 4, bs: 0, cs: 1};
    s3   = '{j: 50,  a: 5,   b: 20, c: 0, bs: 1, cs: 0};
    s4   = '{j: 50,  a: 300, b: 0,  c: 0, bs: 0, cs: 0};
    s40  = '{j: 10,  a: 40,  b: 0,  c: 0, bs: 0, cs: 0};
    s80  = '{j: 254, a: 80,  b: 0,  c: 0, bs: 0, cs: 0};
    s200 = '{j: 50,  a: 200, b: 0,  c: 0, bs: 0, cs: 0};

    rst_n = 1'b0; in_valid = 1'b0;
    A = '0; B = '0; C = '0; Bsgn = 1'b0; Csgn = 1'b0;
`ifdef PWM_COMBINE_STATUS_EN
    stat_clr = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_pwm", int'(pwm_out), 0);
    chk("rst_frame", int'(frame), 0);
    chk("rst_underrun", int'(underrun), 0);
    chk("rst_sat", int'(sat), 0);

    rst_n = 1'b1;
    wait_frame(n, hi);
    chk("first_frame_delay", n, 256);
    chk("first_frame_pwm_high", hi, 0);

    // F1: idle frame after reset, inject 100+10-4
    run_frame(s2, none, hi, und, sats, badf);
    chk("f1_underrun", und, 1);
    chk("f1_high", hi, 0);
    chk("f1_sat", sats, 0);
    chk("f1_frame_strobe", badf, 0);

    // F2: duty 106, inject 5-20 (negative)
    run_frame(s3, none, hi, und, sats, badf);
    chk("f2_high", hi, 106);
    chk("f2_underrun", und, 0);
    chk("f2_sat", sats, 1);
    chk("f2_frame_strobe", badf, 0);

    // F3: duty 0, inject 300 (over range)
    run_frame(s4, none, hi, und, sats, badf);
    chk("f3_high", hi, 0);
    chk("f3_underrun", und, 0);
    chk("f3_sat", sats, 1);

    // F4: duty 256, two samples, second lands on the wrap cycle
    run_frame(s40, s80, hi, und, sats, badf);
    chk("f4_high", hi, 256);
    chk("f4_underrun", und, 0);
    chk("f4_sat", sats, 0);

    // F5: latest sample wins, simultaneous load is not an underrun
    run_frame(none, none, hi, und, sats, badf);
    chk("f5_high", hi, 80);
    chk("f5_underrun", und, 0);
    chk("f5_sat", sats, 0);

    // F6: no new sample -> underrun and held duty; inject 200
    run_frame(s200, none, hi, und, sats, badf);
    chk("f6_underrun", und, 1);
    chk("f6_high", hi, 80);
    chk("f6_frame_strobe", badf, 0);

`ifdef PWM_COMBINE_STATUS_EN
    chk("sat_cnt_before_rst", int'(sat_cnt), 2);
    chk("und_cnt_before_rst", int'(underrun_cnt), 2);
`endif

    // F7: reset at cnt=128 with duty 200
    for (int k = 0; k < 128; k++) @(negedge clk);
    chk("f7_pwm_at_128", int'(pwm_out), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_pwm", int'(pwm_out), 0);
    chk("midrst_cnt", int'(dut.u_cnt.cnt_q), 0);
    chk("midrst_duty", int'(dut.duty_q), 0);
    chk("midrst_underrun", int'(underrun), 0);
`ifdef PWM_COMBINE_STATUS_EN
    chk("midrst_sat_cnt", int'(sat_cnt), 0);
    chk("midrst_und_cnt", int'(underrun_cnt), 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    wait_frame(n, hi);
    chk("post_rst_delay", n, 256);
    chk("post_rst_wait_high", hi, 0);
    run_frame(none, none, hi, und, sats, badf);
    chk("post_rst_underrun", und, 1);
    chk("post_rst_high", hi, 0);

`ifdef PWM_COMBINE_STATUS_EN
    chk("und_cnt_post_rst", int'(underrun_cnt), 1);
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    chk("stat_clr_und_cnt", int'(underrun_cnt), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
